sgd_weight_update_engine: RTL and testbench

- Parametrised, time-multiplexed successor to the fully-parallel FC weight-update block.
- Holds the FC weight matrix in internal RAM and applies one SGD step, W[i][j] -= lr*err[j]*fc_in[i], one element per cycle via a single pipelined MAC.
- Uses signed fixed point with rounding and saturation.
- Sits after the loss/error stage; the inference datapath reads weights through the read port.

---
 rtl/sgd_weight_update_engine.sv | 178 +++++++++++++++++
 tb/tb_sgd_weight_update_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_weight_update_engine.sv
// rtl/sgd_weight_update_engine.sv - time-multiplexed SGD weight update over an internal FC weight RAM.
// Optional L2 weight decay in the write-back stage when WU_DECAY_EN is defined.
`timescale 1ns/1ps
module sgd_weight_update_engine #(
  parameter int N_IN        = 128,
  parameter int N_OUT       = 10,
  parameter int DW          = 16,
  parameter int FRAC        = 8,
  parameter int DECAY_SHIFT = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_wr_en,
  input  logic [$clog2(N_IN)-1:0]         in_wr_addr,
  input  logic [DW-1:0]                   in_wr_data,
  input  logic                            err_wr_en,
  input  logic [$clog2(N_OUT)-1:0]        err_wr_addr,
  input  logic [DW-1:0]                   err_wr_data,
  input  logic                            w_wr_en,
  input  logic [$clog2(N_IN*N_OUT)-1:0]   w_wr_addr,
  input  logic [DW-1:0]                   w_wr_data,
  input  logic [$clog2(N_IN*N_OUT)-1:0]   w_rd_addr,
  output logic [DW-1:0]                   w_rd_data,
  input  logic [DW-1:0]                   lr,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            sat_flag
);

  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam int NW = N_IN * N_OUT;
  localparam int AW = $clog2(NW);
  localparam int PW = 2 * DW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] VMAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] VMIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  if (FRAC < 1 || DECAY_SHIFT < 0 || DECAY_SHIFT >= DW) begin : g_cfg_check
    $error("sgd_weight_update_engine: FRAC or DECAY_SHIFT out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SCALE, S_UPDATE, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [PW-1:0] rnd(input logic signed [2*DW-1:0] p);
    return (PW'(p) + HALF) >>> FRAC;
  endfunction

  // Result is {clamped, value}; the flag feeds sat_flag.
  function automatic logic [DW:0] clamp(input logic signed [PW-1:0] v);
    if (v > VMAX) return {1'b1, VMAX[DW-1:0]};
    if (v < VMIN) return {1'b1, VMIN[DW-1:0]};
    return {1'b0, v[DW-1:0]};
  endfunction

  state_t                 state;
  logic [OW-1:0]          j_cnt;
  logic [IW-1:0]          i_cnt;
  logic [AW-1:0]          a_cnt;
  logic                   d_cnt;
  logic signed [DW-1:0]   lr_q;

  logic signed [DW-1:0]   fc_mem   [N_IN];
  logic signed [DW-1:0]   err_mem  [N_OUT];
  logic signed [DW-1:0]   serr_mem [N_OUT];
  logic signed [DW-1:0]   w_mem    [NW];

  logic                   s1_vld;
  logic signed [DW-1:0]   s1_w, s1_x, s1_e;
  logic [AW-1:0]          s1_addr;

  logic signed [2*DW-1:0] s_prod, u_prod;
  logic [DW:0]            s_res, d_res, w_res;
  logic signed [DW+1:0]   w_diff;
  logic                   in_ok, err_ok, w_ok, rd_ok;

  always_comb begin
    in_ok  = 32'(in_wr_addr)  < 32'(N_IN);
    err_ok = 32'(err_wr_addr) < 32'(N_OUT);
    w_ok   = 32'(w_wr_addr)   < 32'(NW);
    rd_ok  = 32'(w_rd_addr)   < 32'(NW);
    s_prod = (2*DW)'(lr_q) * (2*DW)'(err_mem[j_cnt]);
    s_res  = clamp(rnd(s_prod));
    u_prod = (2*DW)'(s1_x) * (2*DW)'(s1_e);
    d_res  = clamp(rnd(u_prod));
`ifdef WU_DECAY_EN
    w_diff = (DW+2)'(s1_w) - (DW+2)'($signed(d_res[DW-1:0])) - (DW+2)'(s1_w >>> DECAY_SHIFT);
`else
    w_diff = (DW+2)'(s1_w) - (DW+2)'($signed(d_res[DW-1:0]));
`endif
    w_res  = clamp(PW'(w_diff));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
      w_rd_data <= '0;
      j_cnt     <= '0;
      i_cnt     <= '0;
      a_cnt     <= '0;
      d_cnt     <= 1'b0;
      lr_q      <= '0;
      s1_vld    <= 1'b0;
    end else begin
      done      <= 1'b0;
      s1_vld    <= (state == S_UPDATE);
      w_rd_data <= rd_ok ? w_mem[w_rd_addr] : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lr_q     <= lr;
            sat_flag <= 1'b0;
            busy     <= 1'b1;
            j_cnt    <= '0;
            i_cnt    <= '0;
            a_cnt    <= '0;
            state    <= S_SCALE;
          end
        end
        S_SCALE: begin
          if (s_res[DW]) sat_flag <= 1'b1;
          if (j_cnt == OW'(N_OUT - 1)) begin
            j_cnt <= '0;
            state <= S_UPDATE;
          end else begin
            j_cnt <= j_cnt + OW'(1);
          end
        end
        S_UPDATE: begin
          a_cnt <= a_cnt + AW'(1);
          if (j_cnt == OW'(N_OUT - 1)) begin
            j_cnt <= '0;
            if (i_cnt == IW'(N_IN - 1)) begin
              i_cnt <= '0;
              d_cnt <= 1'b0;
              state <= S_DRAIN;
            end else begin
              i_cnt <= i_cnt + IW'(1);
            end
          end else begin
            j_cnt <= j_cnt + OW'(1);
          end
        end
        S_DRAIN: begin
          d_cnt <= ~d_cnt;
          if (d_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (s1_vld && (d_res[DW] || w_res[DW])) sat_flag <= 1'b1;
    end
  end

  // Storage is not reset; the pipeline write-back owns the RAM port while busy.
  always_ff @(posedge clk) begin
    if (in_wr_en && in_ok && !busy) fc_mem[in_wr_addr] <= in_wr_data;
    if (err_wr_en && err_ok && !busy) err_mem[err_wr_addr] <= err_wr_data;
    if (s1_vld) w_mem[s1_addr] <= w_res[DW-1:0];
    else if (w_wr_en && w_ok && !busy) w_mem[w_wr_addr] <= w_wr_data;
    if (state == S_SCALE) serr_mem[j_cnt] <= s_res[DW-1:0];
    if (state == S_UPDATE) begin
      s1_w    <= w_mem[a_cnt];
      s1_x    <= fc_mem[i_cnt];
      s1_e    <= serr_mem[j_cnt];
      s1_addr <= a_cnt;
    end
  end

endmodule

// File: tb/tb_sgd_weight_update_engine.sv
// tb/tb_sgd_weight_update_engine.sv - directed bench for sgd_weight_update_engine (N_IN=4, N_OUT=2).
`timescale 1ns/1ps
module tb_sgd_weight_update_engine;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_wr_en;
  logic [1:0]  in_wr_addr;
  logic [15:0] in_wr_data;
  logic        err_wr_en;
  logic [0:0]  err_wr_addr;
  logic [15:0] err_wr_data;
  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [15:0] w_wr_data;
  logic [2:0]  w_rd_addr;
  logic [15:0] w_rd_data;
  logic [15:0] lr;
  logic        start;
  logic        busy;
  logic        done;
  logic        sat_flag;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_w [NW];

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } rd_t;
  rd_t sbq[$];

  sgd_weight_update_engine #(
    .N_IN(4), .N_OUT(2), .DW(16), .FRAC(8), .DECAY_SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .err_wr_en(err_wr_en), .err_wr_addr(err_wr_addr), .err_wr_data(err_wr_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .lr(lr), .start(start), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_in(input logic [1:0] a, input logic [15:0] d);
    in_wr_en = 1'b1; in_wr_addr = a; in_wr_data = d;
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic wr_err(input logic [0:0] a, input logic [15:0] d);
    err_wr_en = 1'b1; err_wr_addr = a; err_wr_data = d;
    tick();
    err_wr_en = 1'b0;
  endtask

  task automatic wr_w(input logic [2:0] a, input logic [15:0] d);
    w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
    tick();
    w_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [15:0] e, input string tag);
    rd_t it;
    w_rd_addr = a;
    sbq.push_back('{tag, e});
    tick();
    it = sbq.pop_front();
    check(it.tag, 32'(w_rd_data), 32'(it.exp));
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NW; k++) rd_chk(3'(k), exp_w[k], $sformatf("%s_w%0d", tag, k));
  endtask

  // restart: extra start while busy; blk: buffer/RAM write pulses while busy
  task automatic run_pass(input string tag, input bit restart, input bit blk);
    int n;
    int pulses;
    bit seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    n = 0; pulses = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      start     = restart && (n == 3);
      in_wr_en  = blk && (n == 0 || n == 6);
      err_wr_en = blk && (n == 0 || n == 6);
      w_wr_en   = blk && (n == 0 || n == 6);
      in_wr_addr = 2'd0; in_wr_data = 16'h7F00;
      err_wr_addr = 1'b0; err_wr_data = 16'h7F00;
      w_wr_addr = 3'd7; w_wr_data = 16'h1234;
      tick();
      n++;
      if (done) begin
        seen = 1'b1;
        pulses++;
        check({tag, "_busy_with_done"}, 32'(busy), 32'd0);
      end
    end
    start = 1'b0; in_wr_en = 1'b0; err_wr_en = 1'b0; w_wr_en = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd12);
    repeat (15) begin
      tick();
      if (done) pulses++;
    end
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int dn;
    rst = 1'b0; start = 1'b0; lr = '0;
    in_wr_en = 1'b0; in_wr_addr = '0; in_wr_data = '0;
    err_wr_en = 1'b0; err_wr_addr = '0; err_wr_data = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_rd", 32'(w_rd_data), 32'd0);
    rst = 1'b1;
    tick();

    // basic update + latency + ignored second start
    for (int k = 0; k < NW; k++) begin
      exp_w[k] = (k == 5) ? 16'h0A00 : (16'h0010 + (16'(k) << 8));
      wr_w(3'(k), exp_w[k]);
    end
    for (int i = 0; i < 4; i++) wr_in(2'(i), (i == 2) ? 16'h0300 : 16'h0000);
    wr_err(1'b0, 16'h0000);
    wr_err(1'b1, 16'h0200);
    lr = 16'h0080;
    run_pass("basic", 1'b1, 1'b0);
    exp_w[5] = 16'h0700;
    check_all("basic");
    check("basic_sat", 32'(sat_flag), 32'd0);

    // saturation at the negative rail
    wr_in(2'd2, 16'h0000);
    wr_in(2'd0, 16'h0300);
    wr_err(1'b0, 16'h0200);
    wr_err(1'b1, 16'h0000);
    wr_w(3'd0, 16'h8100);
    run_pass("sat", 1'b0, 1'b0);
    exp_w[0] = 16'h8000;
    rd_chk(3'd0, exp_w[0], "sat_w0");
    rd_chk(3'd1, exp_w[1], "sat_w1");
    rd_chk(3'd5, exp_w[5], "sat_w5");
    check("sat_flag_set", 32'(sat_flag), 32'd1);

    // round half-up: lr=1 LSB, err=0.5 -> serr=1 LSB
    lr = 16'h0001;
    wr_err(1'b0, 16'h0080);
    wr_in(2'd0, 16'h0100);
    wr_w(3'd0, 16'h0200);
    run_pass("round", 1'b0, 1'b0);
    exp_w[0] = 16'h01FF;
    rd_chk(3'd0, exp_w[0], "round_w0");
    check("round_sat_clear", 32'(sat_flag), 32'd0);

    // writes during busy are dropped; a follow-up pass exposes any leak
    run_pass("blk", 1'b0, 1'b1);
    exp_w[0] = 16'h01FE;
    rd_chk(3'd0, exp_w[0], "blk_w0");
    rd_chk(3'd7, exp_w[7], "blk_w7");
    run_pass("blk2", 1'b0, 1'b0);
    exp_w[0] = 16'h01FD;
    rd_chk(3'd0, exp_w[0], "blk2_w0");

    // idle write with same-cycle read returns old data, new data next cycle
    w_wr_en = 1'b1; w_wr_addr = 3'd7; w_wr_data = 16'h1234;
    rd_chk(3'd7, exp_w[7], "rdw_old");
    w_wr_en = 1'b0;
    exp_w[7] = 16'h1234;
    rd_chk(3'd7, exp_w[7], "rdw_new");

    // reset during UPDATE
    lr = 16'h7FFF;
    wr_err(1'b0, 16'h7FFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_sat", 32'(sat_flag), 32'd1);
    rst = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sat", 32'(sat_flag), 32'd0);
    check("mid_rst_rd", 32'(w_rd_data), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    dn = 0;
    repeat (20) begin
      tick();
      if (done) dn++;
    end
    check("mid_no_done", 32'(dn), 32'd0);
    run_pass("post_rst", 1'b0, 1'b0);

    // weight decay pass with zero gradient
    lr = 16'h0000;
    wr_w(3'd3, 16'h1000);
    run_pass("decay", 1'b0, 1'b0);
`ifdef WU_DECAY_EN
    rd_chk(3'd3, 16'h0F00, "decay_w3");
`else
    rd_chk(3'd3, 16'h1000, "decay_w3");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
